// File: rtl/spi_loader_pkg.sv
// spi_loader_pkg: command/response codes, FSM states and timeout width for the SPI boot loader
package spi_loader_pkg;
   localparam logic [7:0] CMD_WRITE = 8'hA5;
   localparam logic [7:0] CMD_GO    = 8'h5A;
   localparam logic [7:0] CMD_PING  = 8'h3C;
   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_PONG  = 8'hC3;
   localparam logic [7:0] RSP_NAK   = 8'hEE;
   localparam int TO_W = 20;
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_BUS, S_GO, S_RESP} state_t;
endpackage

// File: rtl/spi_loader_timeout.sv
// spi_loader_timeout: inter-byte idle counter with clear, enable and expiry at p_timeout_cycles
module spi_loader_timeout
   import spi_loader_pkg::*;
#(
   parameter int p_timeout_cycles = 1048575
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);
   logic [TO_W-1:0] cnt;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clr) cnt <= '0;
      else if (i_en && !o_expired) cnt <= cnt + 1'b1;
   end
   assign o_expired = i_en && (cnt == TO_W'(p_timeout_cycles));
endmodule

// File: rtl/spi_loader.sv
// spi_loader: parses host byte frames, writes words over the bus master port and controls CPU halt/restart
module spi_loader
   import spi_loader_pkg::*;
#(
   parameter bit          p_halt_at_reset  = 1'b1,
   parameter logic [31:0] p_reset_vector   = 32'hf0000000,
   parameter int          p_timeout_cycles = 1048575
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_rx_valid,
   input  logic [7:0]  i_rx_byte,
   output logic        o_rx_ready,
   output logic        o_tx_valid,
   output logic [7:0]  o_tx_byte,
   input  logic        i_tx_ready,
   output logic        o_bus_req,
   input  logic        i_bus_gnt,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   output logic        o_bus_we,
   output logic        o_cpu_halt,
   output logic        o_cpu_rst_pulse,
   output logic [31:0] o_boot_addr,
   output logic        o_busy,
   output logic        o_err
);
   state_t      state, state_nxt;
   logic        wmode, wmode_nxt;
   logic [31:0] addr, addr_nxt, wdata, wdata_nxt, boot, boot_nxt;
   logic [15:0] len, len_nxt;
   logic [1:0]  bcnt, bcnt_nxt;
   logic [7:0]  rsp, rsp_nxt;
   logic        halt, halt_nxt, err, err_nxt;
   logic        acc, expired;
   assign o_rx_ready      = state inside {S_IDLE, S_ADDR, S_LEN, S_DATA};
   assign acc             = i_rx_valid && o_rx_ready;
   assign o_tx_valid      = state == S_RESP;
   assign o_tx_byte       = rsp;
   assign o_bus_req       = state == S_BUS;
   assign o_bus_we        = o_bus_req;
   assign o_bus_addr      = addr;
   assign o_bus_wdata     = wdata;
   assign o_cpu_halt      = halt;
   assign o_cpu_rst_pulse = state == S_GO;
   assign o_boot_addr     = boot;
   assign o_busy          = state != S_IDLE;
   assign o_err           = err;
   spi_loader_timeout #(.p_timeout_cycles(p_timeout_cycles)) u_timeout (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clr     (acc || state_nxt != state),
      .i_en      (state inside {S_ADDR, S_LEN, S_DATA}),
      .o_expired (expired)
   );
   always_comb begin
      state_nxt = state;
      wmode_nxt = wmode;
      addr_nxt  = addr;
      len_nxt   = len;
      wdata_nxt = wdata;
      bcnt_nxt  = bcnt;
      rsp_nxt   = rsp;
      halt_nxt  = halt;
      boot_nxt  = boot;
      err_nxt   = err;
      case (state)
         S_IDLE: begin
            bcnt_nxt = '0;
            if (acc) begin
               if (i_rx_byte == CMD_WRITE) begin
                  state_nxt = S_ADDR;
                  wmode_nxt = 1'b1;
                  halt_nxt  = 1'b1;
               end else if (i_rx_byte == CMD_GO) begin
                  state_nxt = S_ADDR;
                  wmode_nxt = 1'b0;
               end else if (i_rx_byte == CMD_PING) begin
                  state_nxt = S_RESP;
                  rsp_nxt   = RSP_PONG;
                  err_nxt   = 1'b0;
               end else begin
                  state_nxt = S_RESP;
                  rsp_nxt   = RSP_NAK;
                  err_nxt   = 1'b1;
               end
            end
         end
         S_ADDR: if (acc) begin
            addr_nxt = {addr[23:0], i_rx_byte};
            bcnt_nxt = bcnt + 2'd1;
            if (bcnt == 2'd3) begin
               addr_nxt[1:0] = 2'b00;
               state_nxt     = wmode ? S_LEN : S_GO;
            end
         end
         S_LEN: if (acc) begin
            len_nxt  = {len[7:0], i_rx_byte};
            bcnt_nxt = bcnt[0] ? 2'd0 : 2'd1;
            if (bcnt[0]) begin
               state_nxt = ({len[7:0], i_rx_byte} == 16'd0) ? S_RESP : S_DATA;
               rsp_nxt   = RSP_ACK;
            end
         end
         S_DATA: if (acc) begin
            // little-endian: the first byte ends up in wdata[7:0]
            wdata_nxt = {i_rx_byte, wdata[31:8]};
            bcnt_nxt  = bcnt + 2'd1;
            if (bcnt == 2'd3) state_nxt = S_BUS;
         end
         S_BUS: if (i_bus_gnt) begin
            addr_nxt  = addr + 32'd4;
            len_nxt   = len - 16'd1;
            state_nxt = (len == 16'd1) ? S_RESP : S_DATA;
            rsp_nxt   = RSP_ACK;
         end
         S_GO: begin
            boot_nxt  = addr;
            halt_nxt  = 1'b0;
            state_nxt = S_RESP;
            rsp_nxt   = RSP_ACK;
         end
         S_RESP: if (i_tx_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (expired && !acc) begin
         state_nxt = S_RESP;
         rsp_nxt   = RSP_NAK;
         err_nxt   = 1'b1;
      end
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
         wmode <= 1'b0;
         addr  <= '0;
         len   <= '0;
         wdata <= '0;
         bcnt  <= '0;
         rsp   <= '0;
         halt  <= p_halt_at_reset;
         boot  <= p_reset_vector;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         wmode <= wmode_nxt;
         addr  <= addr_nxt;
         len   <= len_nxt;
         wdata <= wdata_nxt;
         bcnt  <= bcnt_nxt;
         rsp   <= rsp_nxt;
         halt  <= halt_nxt;
         boot  <= boot_nxt;
         err   <= err_nxt;
      end
   end
endmodule

// File: tb/tb_spi_loader.sv
// tb_spi_loader: directed plus randomized frame-level check of spi_loader against a transaction model
module tb_spi_loader;
   logic        i_clk = 1'b0, i_rst_n = 1'b0, i_rx_valid = 1'b0, i_tx_ready = 1'b0, i_bus_gnt = 1'b1;
   logic [7:0]  i_rx_byte = 8'h00;
   logic        o_rx_ready, o_tx_valid, o_bus_req, o_bus_we, o_cpu_halt, o_cpu_rst_pulse, o_busy, o_err;
   logic [7:0]  o_tx_byte;
   logic [31:0] o_bus_addr, o_bus_wdata, o_boot_addr;
   int          vectors = 0, miscompares = 0, gnt_mode = 0, pulses = 0;
   logic [63:0] got_q[$], exp_q[$];
   logic [31:0] wq[$];
   logic        exp_halt = 1'b1, exp_err = 1'b0;
   logic [31:0] exp_boot = 32'hf0000000;

   spi_loader #(.p_timeout_cycles(16)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_valid(i_rx_valid), .i_rx_byte(i_rx_byte),
      .o_rx_ready(o_rx_ready), .o_tx_valid(o_tx_valid), .o_tx_byte(o_tx_byte), .i_tx_ready(i_tx_ready),
      .o_bus_req(o_bus_req), .i_bus_gnt(i_bus_gnt), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
      .o_bus_we(o_bus_we), .o_cpu_halt(o_cpu_halt), .o_cpu_rst_pulse(o_cpu_rst_pulse),
      .o_boot_addr(o_boot_addr), .o_busy(o_busy), .o_err(o_err)
   );

   initial forever #5 i_clk = ~i_clk;

   initial forever begin
      @(posedge i_clk);
      #1;
      i_bus_gnt = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   initial forever begin
      @(negedge i_clk);
      if (o_cpu_rst_pulse) pulses++;
      if (o_bus_req && i_bus_gnt) got_q.push_back({o_bus_addr, o_bus_wdata});
   end

   initial begin
      #10000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int n = 0;
      repeat (gap) @(negedge i_clk);
      i_rx_valid = 1'b1;
      i_rx_byte  = b;
      while (!o_rx_ready && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      chk("rx_accept", 64'(o_rx_ready), 64'(1));
      @(negedge i_clk);
      i_rx_valid = 1'b0;
   endtask

   task automatic get_resp(input logic [7:0] exp, input string tag);
      int n = 0;
      i_tx_ready = 1'b0;
      while (!o_tx_valid && n < 400) begin
         @(negedge i_clk);
         n++;
      end
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
      chk({tag, "_valid"}, 64'(o_tx_valid), 64'(1));
      chk({tag, "_byte"}, 64'(o_tx_byte), 64'(exp));
      i_tx_ready = 1'b1;
      @(negedge i_clk);
      i_tx_ready = 1'b0;
      chk({tag, "_idle"}, 64'(o_busy), 64'(0));
   endtask

   task automatic check_state(input string tag, input int exp_pulses);
      chk({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk({tag, "_wr"}, got_q[i], exp_q[i]);
      chk({tag, "_halt"}, 64'(o_cpu_halt), 64'(exp_halt));
      chk({tag, "_boot"}, 64'(o_boot_addr), 64'(exp_boot));
      chk({tag, "_err"}, 64'(o_err), 64'(exp_err));
      chk({tag, "_pulse"}, 64'(pulses), 64'(exp_pulses));
      got_q.delete();
      exp_q.delete();
      pulses = 0;
   endtask

   task automatic do_ping();
      send(8'h3C, 0);
      exp_err = 1'b0;
      get_resp(8'hC3, "ping");
      check_state("ping", 0);
   endtask

   task automatic do_bad(input logic [7:0] b);
      send(b, 0);
      exp_err = 1'b1;
      get_resp(8'hEE, "bad");
      check_state("bad", 0);
   endtask

   task automatic do_go(input logic [31:0] a, input int gap);
      send(8'h5A, 0);
      for (int i = 3; i >= 0; i--) send(a[8*i +: 8], $urandom_range(0, gap));
      exp_boot = a & ~32'h3;
      exp_halt = 1'b0;
      get_resp(8'h06, "go");
      check_state("go", 1);
   endtask

   task automatic do_write(input logic [31:0] a, input int gap);
      logic [15:0] n16 = 16'(wq.size());
      logic [31:0] w;
      send(8'hA5, 0);
      for (int i = 3; i >= 0; i--) send(a[8*i +: 8], $urandom_range(0, gap));
      send(n16[15:8], $urandom_range(0, gap));
      send(n16[7:0], $urandom_range(0, gap));
      for (int k = 0; k < wq.size(); k++) begin
         w = wq[k];
         for (int b = 0; b < 4; b++) send(w[8*b +: 8], $urandom_range(0, gap));
         exp_q.push_back({(a & ~32'h3) + 32'(4 * k), w});
      end
      exp_halt = 1'b1;
      get_resp(8'h06, "write");
      check_state("write", 0);
   endtask

   initial begin
      int n;
      int r;
      logic [7:0] b;
      repeat (3) @(negedge i_clk);
      chk("rst_halt", 64'(o_cpu_halt), 64'(1));
      chk("rst_boot", 64'(o_boot_addr), 64'(32'hf0000000));
      chk("rst_busy", 64'(o_busy), 64'(0));
      chk("rst_tx_valid", 64'(o_tx_valid), 64'(0));
      chk("rst_bus_req", 64'(o_bus_req), 64'(0));
      chk("rst_err", 64'(o_err), 64'(0));
      chk("rst_pulse", 64'(o_cpu_rst_pulse), 64'(0));
      chk("rst_tx_byte", 64'(o_tx_byte), 64'(0));
      i_rst_n = 1'b1;
      @(negedge i_clk);
      do_ping();
      wq = {32'h44332211, 32'h88776655};
      do_write(32'hF0000010, 0);
      wq = {32'hCAFEF00D, 32'h01234567};
      do_write(32'hFFFFFFFF, 0);
      wq.delete();
      do_write(32'h00001000, 0);
      // grant stall longer than the idle timeout must not abort the frame
      gnt_mode = 2;
      @(negedge i_clk);
      send(8'hA5, 0);
      send(8'h00, 0); send(8'h00, 0); send(8'h02, 0); send(8'h00, 0);
      send(8'h00, 0); send(8'h01, 0);
      send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
      for (int i = 0; i < 32; i++) begin
         chk("stall_req", 64'(o_bus_req && o_bus_we), 64'(1));
         chk("stall_addr", 64'(o_bus_addr), 64'(32'h00000200));
         chk("stall_wdata", 64'(o_bus_wdata), 64'(32'hEFBEADDE));
         chk("stall_no_rsp", 64'(o_tx_valid), 64'(0));
         @(negedge i_clk);
      end
      chk("stall_nwr", 64'(got_q.size()), 64'(0));
      gnt_mode = 0;
      exp_q.push_back({32'h00000200, 32'hEFBEADDE});
      get_resp(8'h06, "stall");
      check_state("stall", 0);
      do_go(32'h00000103, 0);
      do_bad(8'h77);
      send(8'hA5, 0);
      send(8'h00, 0);
      exp_halt = 1'b1;
      n = 0;
      while (!o_tx_valid && n < 100) begin
         @(negedge i_clk);
         n++;
      end
      chk("timeout_window", 64'(n >= 16 && n <= 18), 64'(1));
      exp_err = 1'b1;
      get_resp(8'hEE, "timeout");
      check_state("timeout", 0);
      do_go(32'h1234567B, 0);
      do_ping();
      gnt_mode = 1;
      for (int it = 0; it < 24; it++) begin
         r = $urandom_range(0, 9);
         if (r <= 4) begin
            wq.delete();
            repeat ($urandom_range(0, 3)) wq.push_back($urandom);
            do_write($urandom, 2);
         end else if (r <= 6) do_go($urandom, 2);
         else if (r == 7) do_ping();
         else begin
            do b = 8'($urandom_range(0, 255)); while (b == 8'hA5 || b == 8'h5A || b == 8'h3C);
            do_bad(b);
         end
      end
      // reset while a bus request is pending
      gnt_mode = 2;
      @(negedge i_clk);
      send(8'hA5, 0);
      send(8'h00, 0); send(8'h00, 0); send(8'h30, 0); send(8'h00, 0);
      send(8'h00, 0); send(8'h01, 0);
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
      n = 0;
      while (!o_bus_req && n < 20) begin
         @(negedge i_clk);
         n++;
      end
      chk("mid_req", 64'(o_bus_req), 64'(1));
      i_rst_n = 1'b0;
      @(negedge i_clk);
      chk("mid_rst_req", 64'(o_bus_req), 64'(0));
      chk("mid_rst_halt", 64'(o_cpu_halt), 64'(1));
      chk("mid_rst_boot", 64'(o_boot_addr), 64'(32'hf0000000));
      chk("mid_rst_tx", 64'(o_tx_valid), 64'(0));
      chk("mid_rst_busy", 64'(o_busy), 64'(0));
      i_rst_n  = 1'b1;
      gnt_mode = 0;
      exp_halt = 1'b1;
      exp_boot = 32'hf0000000;
      exp_err  = 1'b0;
      repeat (4) @(negedge i_clk);
      chk("post_rst_tx", 64'(o_tx_valid), 64'(0));
      check_state("post_rst", 0);
      do_ping();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
